data_ram_sync: RTL and testbench
================================

# data_ram_sync

Parametrised, synchronous-read data memory for the Harvard CPU's data port. It replaces the fixed 32-word, combinational-read data RAM with a byte-addressed, byte-enabled memory of configurable width and depth. A hardware clear sequence zeroes the array after every reset and holds off the CPU with `waitrequest`. Misaligned and out-of-range accesses are flagged rather than silently aliased.

## Interface
- `DATA_WIDTH`, 32: word width in bits; a multiple of 8, at least 8.
- `DEPTH`, 64: number of words; a power of two, at least 2.
- `ADDR_WIDTH`, 32: width of the byte address.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst_n` in 1: reset is asynchronous and active-low.
- `address` in ADDR_WIDTH: byte address.
- `writedata` in DATA_WIDTH: write data.
- `byteenable` in DATA_WIDTH/8: per-byte write mask; bit i covers bits [8i+7:8i].
- `write_en` in 1: write request.
- `read_en` in 1: read request.
- `readdata` out DATA_WIDTH: registered read data.
- `readvalid` out 1: one-cycle pulse; `readdata` is valid this cycle.
- `waitrequest` out 1: high means requests are ignored this cycle.
- `error` out 1: one-cycle pulse reporting a bad access from the previous cycle.

## Operation
- Derived constants:
  - `BYTE_LSB` = log2(DATA_WIDTH/8).
  - `IDX_W` = log2(DEPTH).
  - Word index = `address[BYTE_LSB+IDX_W-1:BYTE_LSB]`.
- A request is **accepted** when `waitrequest`=0 and (`read_en` or `write_en`).
- A request is **bad** if either condition holds:
  - misaligned: `address[BYTE_LSB-1:0]` != 0.
  - out of range: any of `address[ADDR_WIDTH-1:BYTE_LSB+IDX_W]` != 0.
- Bad request behaviour:
  - Write is suppressed.
  - Read returns all-zero `readdata` with `readvalid`=1.
  - `error`=1 in the following cycle.
- Good write: each byte lane with `byteenable[i]`=1 is updated; other lanes keep their value. A write with `byteenable`=0 is a no-op with no error.
- Good read: `readdata` = the word at the index, registered.
- Read and write in the same cycle at the same index:
  - Default: `readdata` returns the old contents (read-before-write).
  - Forwarding behaviour is covered under Configuration.
- FSM states (shared enum):
  - **CLEAR**: `waitrequest`=1. Counter `clr_idx` runs 0..DEPTH-1 and writes all-zero to one word per cycle. On reaching DEPTH-1, go to READY next cycle.
  - **READY**: `waitrequest`=0. Stays in READY until reset.
- Reset is entered asynchronously from either state:
  - Next state is CLEAR with `clr_idx`=0.
  - Any in-flight read is dropped.
  - The clear restarts from 0 regardless of how far a previous clear had progressed.
- Requests presented while `waitrequest`=1 are ignored. They produce no `readvalid`, no `error` and no write.
- Output reset values: `readdata`=0, `readvalid`=0, `error`=0, `waitrequest`=1.

## Timing
- Clear duration: CLEAR occupies exactly DEPTH cycles after `rst_n` deasserts. The first cycle with `waitrequest`=0 is cycle DEPTH, counting the first rising edge with `rst_n` high as cycle 0.
- Read latency is 1 cycle: accepted at edge N, so `readdata`/`readvalid` are valid after edge N+1.
- `readdata` holds its last value while `readvalid`=0.
- Writes take effect at the accepting edge and are visible to a read accepted at edge N+1.
- Back-to-back reads sustain 1 per cycle. A read and a write can be accepted in the same cycle.
- `error` asserts after edge N+1 for the request accepted at edge N, aligned with `readvalid` when the request was a read.

## Configuration
- Macro: `DATA_RAM_FWD_EN`.
- Defined: on a same-cycle read and write to the same good index, `readdata` returns the merged word:
  - enabled lanes come from `writedata`;
  - other lanes come from the old memory.
- Undefined: read-before-write as above; no forwarding mux is synthesised.

## Structure
- Package `data_ram_pkg` holds:
  - `ram_state_t` enum {CLEAR, READY};
  - function `byte_merge(old, new, be)`;
  - a function computing `BYTE_LSB` from `DATA_WIDTH`.
- One sub-module, `data_ram_clear_ctrl`:
  - owns the FSM and `clr_idx`;
  - outputs `clr_we`, `clr_idx` and `waitrequest`.
- The top level muxes the clear write port against the CPU write port and holds the array and read register.

## Test plan
All scenarios use DATA_WIDTH=32 and DEPTH=64.
1. Reset release:
   - `rst_n` low for 3 cycles, then high.
   - Required: `waitrequest`=1 for exactly 64 cycles, then 0.
   - Required: reading word 0x3F returns 0x00000000 with `readvalid` 1 cycle later.
2. Byte-enable write:
   - Write 0x11223344 to 0x10 with be=4'hF, then 0xAABBCCDD with be=4'b0101.
   - Required: reading 0x10 returns 0x11BB33DD.
3. Bad accesses:
   - Write at 0x06 (misaligned) and read at 0x100 (out of range).
   - Required: each gives `error`=1 the next cycle; the read returns 0 with `readvalid`=1; memory at 0x04 is unchanged.
4. Same-address collision:
   - 0x20 holds 0x0; write 0xDEADBEEF be=4'hF with a simultaneous read of 0x20.
   - Required: `readdata`=0x0 without the macro, 0xDEADBEEF with `DATA_RAM_FWD_EN`.
5. Mid-clear reset:
   - Assert `rst_n` low at clear cycle 30.
   - Required: outputs return to reset values immediately; after release, `waitrequest` stays 1 for a full 64 cycles.
6. Requests during CLEAR:
   - `write_en`=1 at 0x08 during CLEAR.
   - Required: no `error` and no `readvalid`; after READY, 0x08 reads 0x0.

Source files
------------

// File: rtl/data_ram_pkg.sv
// Shared types and helpers for the synchronous data RAM: FSM state enum,
// byte-lane merge and byte-offset width calculation.
package data_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_t;

  // Widest word byte_merge handles; callers zero-extend and truncate.
  localparam int MAX_DW = 256;
  localparam int MAX_BE = MAX_DW / 8;

  function automatic int calc_byte_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic logic [MAX_DW-1:0] byte_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_BE-1:0] be
  );
    logic [MAX_DW-1:0] res;
    for (int i = 0; i < MAX_BE; i++) begin
      res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_ram_clear_ctrl.sv
// Post-reset clear sequencer: walks clr_idx over every word while holding
// off the CPU with waitrequest, then parks in READY until the next reset.
module data_ram_clear_ctrl
  import data_ram_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             clr_we,
  output logic [IDX_W-1:0] clr_idx,
  output logic             waitrequest
);

  ram_state_t       state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
          state_d   = READY;
          clr_idx_d = '0;
        end
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    clr_we      = (state_q == CLEAR);
    waitrequest = (state_q == CLEAR);
  end

  assign clr_idx = clr_idx_q;

endmodule

// File: rtl/data_ram_sync.sv
// Byte-addressed, byte-enabled data RAM with registered read, hardware
// clear after reset and bad-access flagging. DATA_RAM_FWD_EN enables
// write-to-read forwarding on same-index collisions.
module data_ram_sync
  import data_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    write_en,
  input  logic                    read_en,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readvalid,
  output logic                    waitrequest,
  output logic                    error
);

  localparam int BE_W     = DATA_WIDTH / 8;
  localparam int BYTE_LSB = calc_byte_lsb(DATA_WIDTH);
  localparam int IDX_W    = $clog2(DEPTH);
  localparam int IDX_HI   = BYTE_LSB + IDX_W;

  logic             clr_we;
  logic [IDX_W-1:0] clr_idx;

  data_ram_clear_ctrl #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_clear_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_we      (clr_we),
    .clr_idx     (clr_idx),
    .waitrequest (waitrequest)
  );

  logic [IDX_W-1:0] cpu_idx;
  logic             misaligned, out_of_range, bad;
  logic             rd_accept, wr_accept, cpu_wr_good;

  assign cpu_idx = address[IDX_HI-1:BYTE_LSB];

  if (BYTE_LSB > 0) begin : g_misaligned
    assign misaligned = |address[BYTE_LSB-1:0];
  end else begin : g_no_misaligned
    assign misaligned = 1'b0;
  end

  if (ADDR_WIDTH > IDX_HI) begin : g_range
    assign out_of_range = |address[ADDR_WIDTH-1:IDX_HI];
  end else begin : g_no_range
    assign out_of_range = 1'b0;
  end

  assign bad         = misaligned | out_of_range;
  assign rd_accept   = !waitrequest && read_en;
  assign wr_accept   = !waitrequest && write_en;
  assign cpu_wr_good = wr_accept && !bad;

  // Single write port shared by the clear sequencer and the CPU.
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [BE_W-1:0]       wr_be;
  logic [DATA_WIDTH-1:0] wr_data;

  always_comb begin
    wr_en   = cpu_wr_good;
    wr_idx  = cpu_idx;
    wr_be   = byteenable;
    wr_data = writedata;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_idx  = clr_idx;
      wr_be   = '1;
      wr_data = '0;
    end
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; the clear sequence zeroes it, which keeps it mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    rd_word = mem_q[cpu_idx];
`ifdef DATA_RAM_FWD_EN
    if (cpu_wr_good) begin
      rd_word = DATA_WIDTH'(byte_merge(MAX_DW'(mem_q[cpu_idx]), MAX_DW'(writedata),
                                       MAX_BE'(byteenable)));
    end
`endif
  end

  logic [DATA_WIDTH-1:0] readdata_q, readdata_d;
  logic                  readvalid_q, readvalid_d;
  logic                  error_q, error_d;

  always_comb begin
    readdata_d  = readdata_q;
    readvalid_d = rd_accept;
    error_d     = (rd_accept || wr_accept) && bad;
    if (rd_accept) readdata_d = bad ? '0 : rd_word;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readdata_q  <= '0;
      readvalid_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      readdata_q  <= readdata_d;
      readvalid_q <= readvalid_d;
      error_q     <= error_d;
    end
  end

  assign readdata  = readdata_q;
  assign readvalid = readvalid_q;
  assign error     = error_q;

endmodule

// File: tb/tb_data_ram_sync.sv
// Self-checking bench for data_ram_sync (DATA_WIDTH=32, DEPTH=64): vector
// table plus reset/clear sequences, expectations queued per request.
module tb_data_ram_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        write_en;
  logic        read_en;
  logic [31:0] readdata;
  logic        readvalid;
  logic        waitrequest;
  logic        error;

  data_ram_sync #(
    .DATA_WIDTH (32),
    .DEPTH      (64),
    .ADDR_WIDTH (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .address     (address),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .write_en    (write_en),
    .read_en     (read_en),
    .readdata    (readdata),
    .readvalid   (readvalid),
    .waitrequest (waitrequest),
    .error       (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_rv;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        rv;
    logic [31:0] data;
    logic        err;
  } exp_t;

  localparam int NVEC = 19;

  vec_t        vecs [NVEC];
  exp_t        sb_q [$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] last_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_readdata"},    readdata,         32'h0);
    check({tag, "_readvalid"},   32'(readvalid),   32'h0);
    check({tag, "_error"},       32'(error),       32'h0);
    check({tag, "_waitrequest"}, 32'(waitrequest), 32'h1);
  endtask

  // Starts at a negedge; drives one request, checks the cycle after the edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e, got;
    read_en    = v.rd;
    write_en   = v.wr;
    address    = v.addr;
    writedata  = v.wdata;
    byteenable = v.be;
    e.rv   = v.exp_rv;
    e.err  = v.exp_err;
    e.data = v.exp_rv ? v.exp_data : last_rdata;
    if (v.exp_rv) last_rdata = v.exp_data;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    read_en  = 1'b0;
    write_en = 1'b0;
    got = sb_q.pop_front();
    check({tag, "_readvalid"},   32'(readvalid),   32'(got.rv));
    check({tag, "_readdata"},    readdata,         got.data);
    check({tag, "_error"},       32'(error),       32'(got.err));
    check({tag, "_waitrequest"}, 32'(waitrequest), 32'h0);
    @(negedge clk);
  endtask

  // Starts at the negedge of reset release; returns at the first negedge with waitrequest low.
  task automatic wait_clear(output int cnt, output int spurious);
    cnt      = 0;
    spurious = 0;
    for (int k = 0; k < 200; k++) begin
      if (!waitrequest) break;
      cnt++;
      if (readvalid || error) spurious++;
      @(negedge clk);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input logic exp_rv, input logic [31:0] exp_data,
                              input logic exp_err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be;
    v.exp_rv = exp_rv; v.exp_data = exp_data; v.exp_err = exp_err;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   cnt, spurious;
    vec_t v;

    vecs[0]  = mk(1, 0, 32'h0000_00FC, 32'h0,         4'h0, 1, 32'h0000_0000, 0);
    vecs[1]  = mk(0, 1, 32'h0000_0010, 32'h1122_3344, 4'hF, 0, 32'h0,         0);
    vecs[2]  = mk(0, 1, 32'h0000_0010, 32'hAABB_CCDD, 4'h5, 0, 32'h0,         0);
    vecs[3]  = mk(1, 0, 32'h0000_0010, 32'h0,         4'h0, 1, 32'h11BB_33DD, 0);
    vecs[4]  = mk(0, 1, 32'h0000_0004, 32'h5566_7788, 4'hF, 0, 32'h0,         0);
    vecs[5]  = mk(0, 1, 32'h0000_0006, 32'h9999_9999, 4'hF, 0, 32'h0,         1);
    vecs[6]  = mk(1, 0, 32'h0000_0100, 32'h0,         4'h0, 1, 32'h0000_0000, 1);
    vecs[7]  = mk(1, 0, 32'h0000_0004, 32'h0,         4'h0, 1, 32'h5566_7788, 0);
    vecs[8]  = mk(1, 0, 32'h0000_0008, 32'h0,         4'h0, 1, 32'h0000_0000, 0);
    vecs[9]  = mk(0, 1, 32'h0000_0020, 32'h1234_5678, 4'h0, 0, 32'h0,         0);
`ifdef DATA_RAM_FWD_EN
    vecs[10] = mk(1, 1, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 1, 32'hDEAD_BEEF, 0);
`else
    vecs[10] = mk(1, 1, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 1, 32'h0000_0000, 0);
`endif
    vecs[11] = mk(1, 0, 32'h0000_0020, 32'h0,         4'h0, 1, 32'hDEAD_BEEF, 0);
`ifdef DATA_RAM_FWD_EN
    vecs[12] = mk(1, 1, 32'h0000_0020, 32'h0000_CAFE, 4'h3, 1, 32'hDEAD_CAFE, 0);
`else
    vecs[12] = mk(1, 1, 32'h0000_0020, 32'h0000_CAFE, 4'h3, 1, 32'hDEAD_BEEF, 0);
`endif
    vecs[13] = mk(1, 0, 32'h0000_0020, 32'h0,         4'h0, 1, 32'hDEAD_CAFE, 0);
    vecs[14] = mk(1, 0, 32'h4000_0010, 32'h0,         4'h0, 1, 32'h0000_0000, 1);
    vecs[15] = mk(1, 0, 32'h0000_0011, 32'h0,         4'h0, 1, 32'h0000_0000, 1);
    vecs[16] = mk(0, 0, 32'h0000_0000, 32'h0,         4'h0, 0, 32'h0,         0);
    vecs[17] = mk(0, 1, 32'h0000_00FC, 32'hA5A5_A5A5, 4'h8, 0, 32'h0,         0);
    vecs[18] = mk(1, 0, 32'h0000_00FC, 32'h0,         4'h0, 1, 32'hA500_0000, 0);

    rst_n      = 1'b0;
    address    = '0;
    writedata  = '0;
    byteenable = '0;
    write_en   = 1'b0;
    read_en    = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");

    // Requests held during the whole clear must be ignored.
    write_en   = 1'b1;
    read_en    = 1'b1;
    address    = 32'h0000_0008;
    writedata  = 32'hFFFF_FFFF;
    byteenable = 4'hF;
    rst_n      = 1'b1;
    wait_clear(cnt, spurious);
    write_en   = 1'b0;
    read_en    = 1'b0;
    check("clear_len", 32'(cnt), 32'd64);
    check("clear_quiet", 32'(spurious), 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i], $sformatf("v%0d", i));
    end

    // In-flight read result is dropped by an asynchronous reset.
    read_en = 1'b1;
    address = 32'h0000_0010;
    @(posedge clk);
    #1;
    read_en = 1'b0;
    check("inflight_readvalid", 32'(readvalid), 32'h1);
    check("inflight_readdata", readdata, 32'h11BB_33DD);
    rst_n = 1'b0;
    #1;
    check_reset("inflight_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset again partway through the clear.
    repeat (30) @(posedge clk);
    #1;
    check("midclear_wait", 32'(waitrequest), 32'h1);
    rst_n = 1'b0;
    #1;
    check_reset("midclear_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_rdata = '0;
    wait_clear(cnt, spurious);
    check("reclear_len", 32'(cnt), 32'd64);
    check("reclear_quiet", 32'(spurious), 32'd0);

    v = mk(1, 0, 32'h0000_0010, 32'h0, 4'h0, 1, 32'h0, 0);
    apply(v, "post_rd10");
    v = mk(1, 0, 32'h0000_00FC, 32'h0, 4'h0, 1, 32'h0, 0);
    apply(v, "post_rdfc");
    v = mk(1, 0, 32'h0000_0004, 32'h0, 4'h0, 1, 32'h0, 0);
    apply(v, "post_rd04");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
